// File: rtl/booth_pkg.sv
// booth_pkg: shared state/op encodings and iteration-count helpers for the radix-4 Booth controller
package booth_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_LOAD_A, S_LOAD_Q, S_DECODE, S_ADD_M, S_ADD_2M,
      S_SUB_M, S_SUB_2M, S_NOP, S_SHIFT, S_LAST_SHIFT, S_DONE
   } state_e;
   typedef enum logic [2:0] {OP_NOP, OP_ADD_M, OP_ADD_2M, OP_SUB_M, OP_SUB_2M} op_e;
   // Unsigned operands take one extra iteration to absorb the zero-extension bits
   function automatic int iter(int width, logic sgn);
      return sgn ? width / 2 : width / 2 + 1;
   endfunction
   function automatic int cnt_w(int width);
      return $clog2(width / 2 + 2);
   endfunction
endpackage

// File: rtl/booth4_ctrl_param_if.sv
// booth4_ctrl_param_if: datapath-facing control/status bundle of the Booth controller
interface booth4_ctrl_param_if #(parameter int CNT_W = 3);
   logic start, mode_signed, abort, done_ack, q1, q0, q;
   logic load_a, load_q, add_en, sel_2m, sub, shift, out_en, done, busy;
   logic [CNT_W-1:0] cnt;
   modport master (
      output start, mode_signed, abort, done_ack, q1, q0, q,
      input load_a, load_q, add_en, sel_2m, sub, shift, out_en, done, busy, cnt
   );
   modport slave (
      input start, mode_signed, abort, done_ack, q1, q0, q,
      output load_a, load_q, add_en, sel_2m, sub, shift, out_en, done, busy, cnt
   );
endinterface

// File: rtl/booth4_recoder.sv
// booth4_recoder: maps a radix-4 Booth triplet {q1,q0,q} to an operation code
module booth4_recoder
   import booth_pkg::*;
(
   input  logic [2:0] bits_i,
   output op_e        op_o
);
   always_comb
      op_o = (bits_i == 3'b011) ? OP_ADD_2M :
             (bits_i == 3'b100) ? OP_SUB_2M :
             (bits_i == 3'b001 || bits_i == 3'b010) ? OP_ADD_M :
             (bits_i == 3'b101 || bits_i == 3'b110) ? OP_SUB_M : OP_NOP;
endmodule

// File: rtl/booth4_ctrl_param.sv
// booth4_ctrl_param: Moore FSM sequencing a radix-4 Booth multiplier datapath
module booth4_ctrl_param
   import booth_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit HOLD_DONE = 1'b0
) (
   input logic               clk,
   input logic               rst,
   booth4_ctrl_param_if.slave bus
);
   localparam int CNT_W = cnt_w(WIDTH);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   op_e              op;
   logic             last;
   booth4_recoder u_rec (.bits_i({bus.q1, bus.q0, bus.q}), .op_o(op));
   assign last = cnt_q == CNT_W'(iter(WIDTH, mode_q) - 1);
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE: if (bus.start) begin
            state_d = S_LOAD_A;
            mode_d  = bus.mode_signed;
         end
         S_LOAD_A: state_d = S_LOAD_Q;
         S_LOAD_Q: begin
            state_d = S_DECODE;
            cnt_d   = '0;
         end
         S_DECODE: state_d = (op == OP_ADD_M)  ? S_ADD_M  :
                             (op == OP_ADD_2M) ? S_ADD_2M :
                             (op == OP_SUB_M)  ? S_SUB_M  :
                             (op == OP_SUB_2M) ? S_SUB_2M : S_NOP;
         S_ADD_M, S_ADD_2M, S_SUB_M, S_SUB_2M, S_NOP: state_d = last ? S_LAST_SHIFT : S_SHIFT;
         S_SHIFT: begin
            state_d = S_DECODE;
            cnt_d   = cnt_q + CNT_W'(1);
         end
         S_LAST_SHIFT: state_d = S_DONE;
         S_DONE: state_d = (!HOLD_DONE || bus.done_ack) ? S_IDLE : S_DONE;
         default: state_d = S_IDLE;
      endcase
      // Abort beats every other transition and freezes the counter
      if (bus.abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         cnt_d   = cnt_q;
      end
   end
   assign bus.load_a = state_q == S_LOAD_A;
   assign bus.load_q = state_q == S_LOAD_Q;
   assign bus.add_en = state_q inside {S_ADD_M, S_ADD_2M, S_SUB_M, S_SUB_2M};
   assign bus.sel_2m = state_q inside {S_ADD_2M, S_SUB_2M};
   assign bus.sub    = state_q inside {S_SUB_M, S_SUB_2M};
   assign bus.shift  = state_q inside {S_SHIFT, S_LAST_SHIFT};
   assign bus.out_en = state_q == S_DONE;
   assign bus.done   = state_q == S_DONE;
   assign bus.busy   = state_q != S_IDLE;
   assign bus.cnt    = cnt_q;
endmodule

// File: tb/tb_booth4_ctrl_param.sv
// tb_booth4_ctrl_param: directed per-cycle trace scoreboard over three controller configurations
module tb_booth4_ctrl_param;
   typedef enum {I, LA, LQ, D, AM, A2, SM, S2, N, SH, LS, DN} st_t;
   typedef struct {int ln; st_t st; int c;} exp_t;
   typedef logic [2:0] b3_t;
   logic clk = 1'b0;
   logic rst0, rst1, rst2;
   logic [7:0] drv [3];
   exp_t sb[$];
   int ecnt [3] = '{0, 0, 0};
   b3_t pb[$];
   st_t po[$];
   int cmp = 0, err = 0;
   always #5 clk = ~clk;
   booth4_ctrl_param_if #(.CNT_W(booth_pkg::cnt_w(8)))  if0();
   booth4_ctrl_param_if #(.CNT_W(booth_pkg::cnt_w(8)))  if1();
   booth4_ctrl_param_if #(.CNT_W(booth_pkg::cnt_w(16))) if2();
   booth4_ctrl_param #(.WIDTH(8),  .HOLD_DONE(1'b0)) u0 (.clk(clk), .rst(rst0), .bus(if0));
   booth4_ctrl_param #(.WIDTH(8),  .HOLD_DONE(1'b1)) u1 (.clk(clk), .rst(rst1), .bus(if1));
   booth4_ctrl_param #(.WIDTH(16), .HOLD_DONE(1'b0)) u2 (.clk(clk), .rst(rst2), .bus(if2));
   assign {rst0, if0.start, if0.mode_signed, if0.abort, if0.done_ack, if0.q1, if0.q0, if0.q} = drv[0];
   assign {rst1, if1.start, if1.mode_signed, if1.abort, if1.done_ack, if1.q1, if1.q0, if1.q} = drv[1];
   assign {rst2, if2.start, if2.mode_signed, if2.abort, if2.done_ack, if2.q1, if2.q0, if2.q} = drv[2];
   wire [8:0] a0 = {if0.load_a, if0.load_q, if0.add_en, if0.sel_2m, if0.sub, if0.shift, if0.out_en, if0.done, if0.busy};
   wire [8:0] a1 = {if1.load_a, if1.load_q, if1.add_en, if1.sel_2m, if1.sub, if1.shift, if1.out_en, if1.done, if1.busy};
   wire [8:0] a2 = {if2.load_a, if2.load_q, if2.add_en, if2.sel_2m, if2.sub, if2.shift, if2.out_en, if2.done, if2.busy};
   function automatic logic [8:0] outs(st_t s);
      return {s == LA, s == LQ, s inside {AM, A2, SM, S2}, s inside {A2, S2}, s inside {SM, S2},
              s inside {SH, LS}, s == DN, s == DN, s != I};
   endfunction
   // Expect state st during the coming cycle and apply the given inputs for it
   task automatic cyc(int ln, st_t st, logic s = 0, logic m = 1, logic ab = 0, logic ak = 0,
                      logic [2:0] b = 3'b000, logic r = 0);
      @(posedge clk);
      #1;
      sb.push_back('{ln, st, ecnt[ln]});
      if (r) ecnt[ln] = 0;
      else if (!(ab && st != I)) ecnt[ln] = (st == LQ) ? 0 : (st == SH) ? ecnt[ln] + 1 : ecnt[ln];
      drv[ln] = {r, s, m, ab, ak, b};
   endtask
   task automatic run(int ln, logic sgn);
      cyc(ln, I, 1, sgn);
      cyc(ln, LA);
      cyc(ln, LQ);
      foreach (pb[i]) begin
         cyc(ln, D, 0, 1, 0, 0, pb[i]);
         cyc(ln, po[i]);
         cyc(ln, (i == pb.size() - 1) ? LS : SH);
      end
   endtask
   always @(negedge clk)
      if (sb.size() > 0) begin
         exp_t e;
         logic [8:0] a;
         int ac;
         e = sb.pop_front();
         a = (e.ln == 0) ? a0 : (e.ln == 1) ? a1 : a2;
         ac = (e.ln == 0) ? int'(if0.cnt) : (e.ln == 1) ? int'(if1.cnt) : int'(if2.cnt);
         cmp++;
         if (a !== outs(e.st) || ac != e.c) begin
            err++;
            $display("FAIL lane%0d state %s: got outs=%b cnt=%0d, want outs=%b cnt=%0d",
                     e.ln, e.st.name(), a, ac, outs(e.st), e.c);
         end
      end
   initial begin
      for (int k = 0; k < 3; k++) drv[k] = 8'b1010_0000;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) drv[k] = 8'b0010_0000;
      // Reset state and signed 8-bit run: 15 cycles to a single done pulse
      cyc(0, I);
      pb = '{3'b011, 3'b100, 3'b001, 3'b000};
      po = '{A2, S2, AM, N};
      run(0, 1);
      cyc(0, DN, 0, 1, 0, 1);
      cyc(0, I, 0, 1, 0, 1);
      // Unsigned 8-bit: five iterations, mode latched only at start
      pb = '{3'b001, 3'b010, 3'b101, 3'b110, 3'b111};
      po = '{AM, AM, SM, SM, N};
      run(0, 0);
      cyc(0, DN);
      cyc(0, I);
      // Abort in the third DECODE, then a clean full run
      cyc(0, I, 1);
      cyc(0, LA);
      cyc(0, LQ);
      for (int i = 0; i < 2; i++) begin
         cyc(0, D, 0, 1, 0, 0, 3'b001);
         cyc(0, AM);
         cyc(0, SH);
      end
      cyc(0, D, 0, 1, 1, 0, 3'b011);
      cyc(0, I);
      pb = '{3'b011, 3'b100, 3'b001, 3'b000};
      po = '{A2, S2, AM, N};
      run(0, 1);
      cyc(0, DN);
      cyc(0, I);
      // Reset in SUB_M, then reset together with abort in SHIFT
      cyc(0, I, 1);
      cyc(0, LA);
      cyc(0, LQ);
      for (int i = 0; i < 2; i++) begin
         cyc(0, D, 0, 1, 0, 0, 3'b001);
         cyc(0, AM);
         cyc(0, SH);
      end
      cyc(0, D, 0, 1, 0, 0, 3'b101);
      cyc(0, SM, 0, 1, 0, 0, 3'b000, 1);
      cyc(0, I);
      cyc(0, I, 1);
      cyc(0, LA);
      cyc(0, LQ);
      cyc(0, D);
      cyc(0, N);
      cyc(0, SH);
      cyc(0, D);
      cyc(0, N);
      cyc(0, SH, 0, 1, 1, 0, 3'b000, 1);
      cyc(0, I);
      // Held done: ack ignored in IDLE, start ignored in DONE, ack releases
      cyc(1, I, 0, 1, 0, 1);
      pb = '{3'b011, 3'b100, 3'b001, 3'b000};
      po = '{A2, S2, AM, N};
      run(1, 1);
      repeat (10) cyc(1, DN, 1);
      cyc(1, DN, 1, 1, 0, 1);
      cyc(1, I);
      cyc(1, I);
      run(1, 1);
      cyc(1, DN);
      cyc(1, DN, 0, 1, 1);
      cyc(1, I);
      cyc(1, I);
      // 16-bit signed: all eight recode triplets, 27 cycles to done
      cyc(2, I);
      pb = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
      po = '{N, AM, AM, A2, S2, SM, SM, N};
      run(2, 1);
      cyc(2, DN);
      cyc(2, I);
      @(posedge clk);
      @(negedge clk);
      #1;
      cmp++;
      if (sb.size() != 0) begin
         err++;
         $display("FAIL scoreboard drain: got %0d pending, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end
endmodule

// File: doc/booth4_ctrl_param.md
BOOTH4_CTRL_PARAM -- requirements
Module: booth4_ctrl_param

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be even and >= 4.
REQ-002 Parameter HOLD_DONE, default 0: 0 = one-cycle done pulse; 1 = done held until done_ack.
REQ-003 Derived constant CNT_W = clog2(WIDTH/2+2): iteration counter width.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- mode_signed  in  1  1 = signed operands, 0 = unsigned; latched when start is accepted.
- abort  in  1  cancel the operation in progress.
- done_ack  in  1  releases done when HOLD_DONE=1.
- q1, q0, q  in  1 each  Booth recode bits from the datapath.
- load_a  out  1  load multiplicand/accumulator.
- load_q  out  1  load multiplier register.
- add_en  out  1  accumulator update this cycle.
- sel_2m  out  1  select 2M rather than M.
- sub  out  1  subtract rather than add.
- shift  out  1  arithmetic shift of A:Q by 2.
- out_en  out  1  drive the result.
- done  out  1  result valid.
- busy  out  1  high in every state except IDLE.
- cnt  out  CNT_W  current iteration index.

Function
REQ-006 States: IDLE, LOAD_A, LOAD_Q, DECODE, ADD_M, ADD_2M, SUB_M, SUB_2M, NOP, SHIFT, LAST_SHIFT, DONE.
REQ-007 IDLE goes to LOAD_A when start=1 and stays in IDLE otherwise; mode_signed is latched on the same edge.
REQ-008 LOAD_A goes to LOAD_Q; LOAD_Q goes to DECODE and clears cnt to 0.
REQ-009 DECODE selects the next state from {q1,q0,q}:
- 000 or 111 -> NOP
- 001 or 010 -> ADD_M
- 011 -> ADD_2M
- 100 -> SUB_2M
- 101 or 110 -> SUB_M
REQ-010 ITER = WIDTH/2 when the latched mode is signed, WIDTH/2+1 when unsigned; the unsigned case uses the extra iteration for zero-extension.
REQ-011 Every operation state (ADD_*, SUB_*, NOP) goes to LAST_SHIFT when cnt == ITER-1 and to SHIFT otherwise.
REQ-012 SHIFT increments cnt and returns to DECODE.
REQ-013 LAST_SHIFT goes to DONE.
REQ-014 DONE exit: with HOLD_DONE=0 it goes to IDLE after one cycle; with HOLD_DONE=1 it stays until done_ack=1, then goes to IDLE.
REQ-015 Outputs are Moore and decoded from the state only:
- load_a = LOAD_A; load_q = LOAD_Q.
- add_en = ADD_M | ADD_2M | SUB_M | SUB_2M.
- sel_2m = ADD_2M | SUB_2M.
- sub = SUB_M | SUB_2M.
- shift = SHIFT | LAST_SHIFT.
- out_en = DONE; done = DONE.
REQ-016 Latency from the edge that accepts start to the first cycle with done=1 is 3 + 3*ITER cycles.
REQ-017 abort=1 in any non-IDLE state sends the block to IDLE on the next edge, with no done pulse; abort has priority over all other transitions.
REQ-018 start is ignored while busy=1, including in DONE; no request is queued.
REQ-019 done_ack is ignored outside DONE, and ignored entirely when HOLD_DONE=0.
REQ-020 No illegal state is reachable; any unused encoding SHALL go to IDLE on the next edge.
REQ-021 cnt holds its value except when cleared in LOAD_Q or incremented in SHIFT; it never exceeds ITER-1.

Reset
REQ-022 rst=1 at a rising edge forces IDLE, cnt=0 and latched mode=signed; all outputs are 0 in the following cycle.
REQ-023 Reset overrides abort, start and done_ack, and takes effect mid-operation with no done pulse.

Structure
REQ-024 A shared package/header booth_pkg SHALL hold:
- the state encoding constants;
- the Booth recode operation codes (NOP, ADD_M, ADD_2M, SUB_M, SUB_2M);
- the ITER and CNT_W derivation helpers.
REQ-025 A single combinational sub-module booth4_recoder SHALL map {q1,q0,q} to a booth_pkg operation code; the FSM instantiates it once.

Verification
REQ-026 Scenario 1 (default WIDTH=8, HOLD_DONE=0): signed, start pulse, datapath recode bits 011,100,001,000 -> DECODE routes to ADD_2M, SUB_2M, ADD_M, NOP in that order; done pulses for one cycle exactly 15 cycles after acceptance.
REQ-027 Scenario 2: WIDTH=8, unsigned -> 5 iterations and done 18 cycles after acceptance; cnt observed as 0..4 across the SHIFT cycles.
REQ-028 Scenario 3: HOLD_DONE=1 -> done stays high for 10 cycles with done_ack=0; done_ack=1 gives IDLE on the next edge; start held high during DONE is not accepted.
REQ-029 Scenario 4: abort=1 during the third DECODE -> IDLE next cycle, done never asserted, busy=0; a following start runs the full 15-cycle sequence.
REQ-030 Scenario 5: rst=1 in SUB_M -> next cycle all outputs 0 and cnt=0; simultaneous rst and abort behave as reset.
REQ-031 Scenario 6: WIDTH=16 signed -> 8 iterations, done 27 cycles after acceptance; all eight recode patterns exercised with a one-hot check on add_en/sel_2m/sub.
